input_cond_bank: RTL and testbench

//   Parametrised N-channel conditioner for asynchronous board inputs (push-buttons, slide switches).
//   Per channel: multi-stage synchroniser, counter-based debounce FSM, registered level output and one-cycle rise/fall pulses.

---
 rtl/input_cond_pkg.sv | 22 ++
 rtl/db_channel.sv | 126 ++++++++++++
 rtl/input_cond_bank.sv | 35 +++
 tb/tb_input_cond_bank.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and constants for the input conditioning bank.
// Holds the debounce state encoding, the default debounce length and a
// helper that sizes the per-channel debounce counter.
package input_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } db_state_t;

  // 10 ms worth of 50 MHz clock cycles
  localparam int DB_CYCLES_10MS_50MHZ = 500_000;

  // Counter width for a debounce length; a single-cycle debounce still
  // needs one bit so the counter never collapses to zero width
  function automatic int cntWidth(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/db_channel.sv
// One conditioned input: synchroniser chain, debounce FSM with its counter,
// registered level and one-cycle rise/fall pulses.
// Optional feature: INPUT_COND_TOGGLE_EN adds a press-to-toggle flop;
// without it the toggle output is tied low and no flop exists.
module db_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_10MS_50MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int CNT_W = cntWidth(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   syncBit;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift the asynchronous pin through the synchroniser chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) syncChain_q <= '0;
    else      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], raw};
  end

  assign syncBit = syncChain_q[SYNC_STAGES-1];

  // Debounce decision: a new value must survive the whole WAIT window,
  // any return to the old value drops straight back to the stable state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (syncBit) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!syncBit) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!syncBit) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (syncBit) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Register FSM state, counter, level and the edge pulses together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef INPUT_COND_TOGGLE_EN
  logic toggle_q;

  // Flip the toggle on the same edge that raises the rise pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) toggle_q <= 1'b0;
    else      toggle_q <= toggle_q ^ rise_d;
  end

  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: rtl/input_cond_bank.sv
// Bank of independent input conditioners between the board pins and user
// logic. Each channel is a db_channel; outputs are gathered into vectors.
// Optional feature: INPUT_COND_TOGGLE_EN (press-to-toggle outputs).
module input_cond_bank
  import input_cond_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_10MS_50MHZ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] toggle
);

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    db_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) uChannel (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .toggle(toggle[i])
    );
  end

endmodule

// File: tb/tb_input_cond_bank.sv
// Self-checking bench for input_cond_bank (4 channels, 2 sync stages,
// debounce length 4). Builds with or without INPUT_COND_TOGGLE_EN.
module tb_input_cond_bank;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int DB = 4;
`ifdef INPUT_COND_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  logic [N-1:0] level, rise, fall, toggle;

  int checks = 0;
  int errors = 0;
  bit compareEn = 1'b0;
  int riseCnt [N];
  int fallCnt [N];

  input_cond_bank #(
    .N_CH       (N),
    .SYNC_STAGES(S),
    .DB_CYCLES  (DB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .toggle(toggle)
  );

  always #5 clk = ~clk;

  // Reference model: a channel's level flips once the synchronised input
  // has disagreed with it for DB+1 consecutive samples
  logic [S-1:0] mSync [N];
  int           runLen [N];
  logic [N-1:0] expLevel, expRise, expFall, expToggle;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < N; ch++) begin
        mSync[ch]  = '0;
        runLen[ch] = 0;
      end
      expLevel  = '0;
      expRise   = '0;
      expFall   = '0;
      expToggle = '0;
    end else begin
      expRise = '0;
      expFall = '0;
      for (int ch = 0; ch < N; ch++) begin
        logic sv;
        sv = mSync[ch][S-1];
        if (sv == expLevel[ch]) begin
          runLen[ch] = 0;
        end else begin
          runLen[ch] = runLen[ch] + 1;
          if (runLen[ch] == DB + 1) begin
            expLevel[ch] = sv;
            if (sv) expRise[ch] = 1'b1;
            else    expFall[ch] = 1'b1;
            runLen[ch] = 0;
          end
        end
        mSync[ch] = {mSync[ch][S-2:0], raw[ch]};
      end
      if (TOG) expToggle = expToggle ^ expRise;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (compareEn) begin
      checks++;
      if ({level, rise, fall, toggle} !== {expLevel, expRise, expFall, expToggle}
          || (rise & fall) != '0) begin
        errors++;
        $display("[TB] FAIL model t=%0t lvl/rise/fall/tog actual=%b/%b/%b/%b expected=%b/%b/%b/%b",
                 $time, level, rise, fall, toggle, expLevel, expRise, expFall, expToggle);
      end
    end
  end

  // Pulse counters for the "exactly one / none" checks
  always @(negedge clk) begin
    for (int ch = 0; ch < N; ch++) begin
      if (rise[ch] === 1'b1) riseCnt[ch]++;
      if (fall[ch] === 1'b1) fallCnt[ch]++;
    end
  end

  task automatic clearCounts();
    for (int ch = 0; ch < N; ch++) begin
      riseCnt[ch] = 0;
      fallCnt[ch] = 0;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] value, input int cycles);
    raw = value;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  initial begin
    logic [N-1:0] flips;
    clearCounts();
    #1 rst = 1'b0;
    waitCycles(3);
    compareEn = 1'b1;
    checkOutput("reset_state", {level, rise, fall, toggle}, 16'h0000);
    rst = 1'b1;
    waitCycles(2);

    // Clean press on channel 0
    applyStimulus(4'b0001, 6);
    checkOutput("press_edge6_level", 16'(level), 16'h0);
    waitCycles(1);
    checkOutput("press_edge7_level", 16'(level), 16'h1);
    checkOutput("press_edge7_rise", 16'(rise), 16'h1);
    checkOutput("press_edge7_toggle", 16'(toggle), TOG ? 16'h1 : 16'h0);
    waitCycles(1);
    checkOutput("press_rise_single", 16'(rise), 16'h0);

    // Glitch of 4 cycles rejected, 5 cycles accepted on channel 1
    clearCounts();
    applyStimulus(4'b0011, 4);
    applyStimulus(4'b0001, 10);
    checkOutput("glitch4_level", 16'(level), 16'h1);
    checkOutput("glitch4_rise_cnt", 16'(riseCnt[1]), 16'd0);
    applyStimulus(4'b0011, 6);
    checkOutput("accept_edge6_level", 16'(level), 16'h1);
    waitCycles(1);
    checkOutput("accept_edge7_level", 16'(level), 16'h3);
    checkOutput("accept_edge7_rise", 16'(rise), 16'h2);

    // Release with bounce on channel 2
    applyStimulus(4'b0111, 10);
    checkOutput("bounce_pre_level", 16'(level), 16'h7);
    clearCounts();
    applyStimulus(4'b0011, 1);
    applyStimulus(4'b0111, 1);
    applyStimulus(4'b0011, 1);
    applyStimulus(4'b0111, 1);
    applyStimulus(4'b0011, 6);
    checkOutput("settle_edge6_level", 16'(level), 16'h7);
    waitCycles(1);
    checkOutput("settle_edge7_level", 16'(level), 16'h3);
    checkOutput("settle_edge7_fall", 16'(fall), 16'h4);
    waitCycles(3);
    checkOutput("bounce_fall_cnt", 16'(fallCnt[2]), 16'd1);

    // Asynchronous reset mid-debounce on channel 3
    applyStimulus(4'b1011, 3);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset_outputs", {level, rise, fall, toggle}, 16'h0000);
    waitCycles(2);
    rst = 1'b1;
    clearCounts();
    waitCycles(6);
    checkOutput("post_reset_edge6_level", 16'(level), 16'h0);
    waitCycles(1);
    checkOutput("post_reset_edge7_rise", 16'(rise), 16'hB);
    checkOutput("post_reset_toggle", 16'(toggle), TOG ? 16'hB : 16'h0);
    waitCycles(3);
    checkOutput("post_reset_rise3_cnt", 16'(riseCnt[3]), 16'd1);

    // Simultaneous rise on 0 and 3, channel 3 glitches after 2 cycles
    applyStimulus(4'b0000, 12);
    checkOutput("all_released", 16'(level), 16'h0);
    clearCounts();
    applyStimulus(4'b1001, 2);
    applyStimulus(4'b0001, 4);
    checkOutput("simul_edge6_level", 16'(level), 16'h0);
    waitCycles(1);
    checkOutput("simul_edge7_rise", 16'(rise), 16'h1);
    waitCycles(6);
    checkOutput("simul_rise0_cnt", 16'(riseCnt[0]), 16'd1);
    checkOutput("simul_rise3_cnt", 16'(riseCnt[3]), 16'd0);
    checkOutput("simul_toggle", 16'(toggle), TOG ? 16'hA : 16'h0);

    // Two more accepted presses of channel 0: toggle 0 -> 1 -> 0
    applyStimulus(4'b0000, 12);
    applyStimulus(4'b0001, 6);
    checkOutput("tog_before_rise", 16'(toggle), TOG ? 16'hA : 16'h0);
    waitCycles(1);
    checkOutput("tog_on_rise1", 16'(toggle), TOG ? 16'hB : 16'h0);
    applyStimulus(4'b0000, 12);
    applyStimulus(4'b0001, 7);
    checkOutput("tog_on_rise2", 16'(toggle), TOG ? 16'hA : 16'h0);

    // Randomised phase checked cycle by cycle against the model
    for (int n = 0; n < 2000; n++) begin
      flips = '0;
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 4) == 0) flips[ch] = 1'b1;
      applyStimulus(raw ^ flips, 1);
      if ($urandom_range(0, 9) == 0) waitCycles($urandom_range(3, 8));
    end
    applyStimulus(raw, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
